// File: rtl/lshift_normalizer.sv
// rtl/lshift_normalizer.sv - iterative left-shift mantissa normalizer, one 2^s layer per cycle
module lshift_normalizer #(
   parameter  int WIDTH  = 8,
   parameter  int EXPW   = 5,
   localparam int STAGES = $clog2(WIDTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_mant,
   input  logic [EXPW-1:0]   in_exp,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_mant,
   output logic [EXPW-1:0]   out_exp,
   output logic [STAGES-1:0] out_shamt,
   output logic              out_zero,
   output logic              out_denorm
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t              state_q, state_d;
   logic [STAGES-1:0]   stg_q, stg_d;
   logic [WIDTH-1:0]    mant_q, mant_d;
   logic [EXPW-1:0]     exp_q, exp_d;
   logic [STAGES-1:0]   shamt_q, shamt_d;
   logic [WIDTH-1:0]    out_mant_q, out_mant_d;
   logic [EXPW-1:0]     out_exp_q, out_exp_d;
   logic [STAGES-1:0]   out_shamt_q, out_shamt_d;
   logic                out_zero_q, out_zero_d;
   logic                out_denorm_q, out_denorm_d;

   logic [STAGES-1:0]   amt_s;
   logic [EXPW-1:0]     amt_e;
   logic [WIDTH-1:0]    top_mask;

   always_comb begin
      state_d      = state_q;
      stg_d        = stg_q;
      mant_d       = mant_q;
      exp_d        = exp_q;
      shamt_d      = shamt_q;
      out_mant_d   = out_mant_q;
      out_exp_d    = out_exp_q;
      out_shamt_d  = out_shamt_q;
      out_zero_d   = out_zero_q;
      out_denorm_d = out_denorm_q;

      amt_s    = STAGES'(1) << stg_q;
      amt_e    = EXPW'(1) << stg_q;
      top_mask = ~({WIDTH{1'b1}} >> amt_s);

      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               mant_d  = in_mant;
               exp_d   = in_exp;
               shamt_d = '0;
               stg_d   = STAGES'(STAGES - 1);
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            // exp > amt keeps the exponent at or above 1 after the decrement
            if (((mant_q & top_mask) == '0) && (exp_q > amt_e)) begin
               mant_d  = mant_q << amt_s;
               exp_d   = exp_q - amt_e;
               shamt_d = shamt_q + amt_s;
            end
            if (stg_q == '0) begin
               state_d    = DONE;
               out_zero_d = (mant_q == '0);
               if (mant_q == '0) begin
                  out_mant_d   = '0;
                  out_exp_d    = '0;
                  out_shamt_d  = '0;
                  out_denorm_d = 1'b0;
               end else begin
                  out_mant_d   = mant_d;
                  out_exp_d    = exp_d;
                  out_shamt_d  = shamt_d;
                  out_denorm_d = !mant_d[WIDTH-1];
               end
            end else begin
               stg_d = stg_q - STAGES'(1);
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         stg_q        <= '0;
         mant_q       <= '0;
         exp_q        <= '0;
         shamt_q      <= '0;
         out_mant_q   <= '0;
         out_exp_q    <= '0;
         out_shamt_q  <= '0;
         out_zero_q   <= 1'b0;
         out_denorm_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         stg_q        <= stg_d;
         mant_q       <= mant_d;
         exp_q        <= exp_d;
         shamt_q      <= shamt_d;
         out_mant_q   <= out_mant_d;
         out_exp_q    <= out_exp_d;
         out_shamt_q  <= out_shamt_d;
         out_zero_q   <= out_zero_d;
         out_denorm_q <= out_denorm_d;
      end
   end

   assign in_ready   = (state_q == IDLE);
   assign out_valid  = (state_q == DONE);
   assign out_mant   = out_mant_q;
   assign out_exp    = out_exp_q;
   assign out_shamt  = out_shamt_q;
   assign out_zero   = out_zero_q;
   assign out_denorm = out_denorm_q;

endmodule

// File: tb/tb_lshift_normalizer.sv
// tb/tb_lshift_normalizer.sv - directed self-checking bench for lshift_normalizer
module tb_lshift_normalizer;

   localparam int STAGES = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_mant;
   logic [4:0] in_exp;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_mant;
   logic [4:0] out_exp;
   logic [2:0] out_shamt;
   logic       out_zero;
   logic       out_denorm;

   int vectors     = 0;
   int miscompares = 0;

   lshift_normalizer dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_mant    (in_mant),
      .in_exp     (in_exp),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_mant   (out_mant),
      .out_exp    (out_exp),
      .out_shamt  (out_shamt),
      .out_zero   (out_zero),
      .out_denorm (out_denorm)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_result(input string tag, input logic [7:0] xm, input logic [4:0] xe,
                             input logic [2:0] xs, input logic xz, input logic xd);
      chk({tag, "_mant"},   32'(out_mant),   32'(xm));
      chk({tag, "_exp"},    32'(out_exp),    32'(xe));
      chk({tag, "_shamt"},  32'(out_shamt),  32'(xs));
      chk({tag, "_zero"},   32'(out_zero),   32'(xz));
      chk({tag, "_denorm"}, 32'(out_denorm), 32'(xd));
   endtask

   // Accept edge, then STAGES-1 cycles without out_valid, then out_valid on the STAGES-th edge.
   task automatic run_op(input string tag, input logic [7:0] m, input logic [4:0] e,
                         input logic [7:0] xm, input logic [4:0] xe, input logic [2:0] xs,
                         input logic xz, input logic xd);
      chk({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
      in_mant   = m;
      in_exp    = e;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk({tag, "_busy_ready"}, 32'(in_ready), 32'd0);
      for (int k = 1; k < STAGES; k++) begin
         tick();
         chk({tag, "_early_valid"}, 32'(out_valid), 32'd0);
      end
      tick();
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk_result(tag, xm, xe, xs, xz, xd);
      tick();
      chk({tag, "_ret_ready"}, 32'(in_ready), 32'd1);
      chk({tag, "_ret_valid"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_mant   = '0;
      in_exp    = '0;
      out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk_result("rst", 8'h00, 5'd0, 3'd0, 1'b0, 1'b0);

      run_op("norm",  8'h13, 5'd10, 8'h98, 5'd7, 3'd3, 1'b0, 1'b0);
      run_op("floor", 8'h01, 5'd3,  8'h04, 5'd1, 3'd2, 1'b0, 1'b1);
      run_op("zero",  8'h00, 5'd9,  8'h00, 5'd0, 3'd0, 1'b1, 1'b0);
      run_op("msb",   8'h80, 5'd1,  8'h80, 5'd1, 3'd0, 1'b0, 1'b0);
      run_op("dnin",  8'h05, 5'd0,  8'h05, 5'd0, 3'd0, 1'b0, 1'b1);
      run_op("lsb",   8'h01, 5'd20, 8'h80, 5'd13, 3'd7, 1'b0, 1'b0);

      // Backpressure: results must hold and busy-time in_valid must not be captured.
      in_mant   = 8'h13;
      in_exp    = 5'd10;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      tick();
      in_mant = 8'h01;
      in_exp  = 5'd3;
      for (int k = 0; k < STAGES; k++) tick();
      chk("stall_valid", 32'(out_valid), 32'd1);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("stall_hold_valid", 32'(out_valid), 32'd1);
         chk("stall_hold_ready", 32'(in_ready), 32'd0);
         chk_result("stall", 8'h98, 5'd7, 3'd3, 1'b0, 1'b0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("stall_release_ready", 32'(in_ready), 32'd1);
      chk("stall_release_valid", 32'(out_valid), 32'd0);
      tick();
      chk("stall_no_capture", 32'(in_ready), 32'd1);
      run_op("post_stall", 8'h20, 5'd4, 8'h80, 5'd2, 3'd2, 1'b0, 1'b0);

      // Reset during the second SHIFT cycle drops the operation.
      in_mant  = 8'h13;
      in_exp   = 5'd10;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_ready", 32'(in_ready), 32'd1);
      chk("midrst_valid", 32'(out_valid), 32'd0);
      chk_result("midrst", 8'h00, 5'd0, 3'd0, 1'b0, 1'b0);
      for (int k = 0; k < STAGES + 2; k++) begin
         tick();
         chk("midrst_quiet", 32'(out_valid), 32'd0);
      end
      run_op("post_rst", 8'h13, 5'd10, 8'h98, 5'd7, 3'd3, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
